// File: rtl/legalize_pkg.sv
// Shared types and elaboration helpers for the legalized-datapath word splitter.
package legalize_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } split_state_e;

    function automatic int unsigned num_slices(input int unsigned in_width,
                                               input int unsigned out_width);
        if (out_width == 32'd0) begin
            return 32'd0;
        end else begin
            return in_width / out_width;
        end
    endfunction

    // A legal configuration splits a word into a whole, non-zero number of slices.
    function automatic bit widths_legal(input int unsigned in_width,
                                        input int unsigned out_width);
        if (out_width == 32'd0 || in_width < out_width) begin
            return 1'b0;
        end else begin
            return (in_width % out_width) == 32'd0;
        end
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/legalize_slice_sel.sv
// Combinational slice mux: picks the OUT_WIDTH slice of a word addressed by idx.
// Slice order reverses (MSB first) when LEGALIZE_SPLIT_MSB_FIRST_EN is defined.
module legalize_slice_sel
    import legalize_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = 1
) (
    input  logic [IN_WIDTH-1:0]  word,
    input  logic [IDX_WIDTH-1:0] idx,
    output logic [OUT_WIDTH-1:0] slice
);

    localparam int unsigned N = num_slices(IN_WIDTH, OUT_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 32'd1);

    logic [IDX_WIDTH-1:0] pos_s;

    // Map the emission index onto the physical slice position and select it.
    always_comb begin
`ifdef LEGALIZE_SPLIT_MSB_FIRST_EN
        pos_s = LAST_IDX - idx;
`else
        pos_s = idx;
`endif
        slice = word[pos_s*OUT_WIDTH +: OUT_WIDTH];
    end

endmodule

// File: rtl/legalize_word_splitter.sv
// Splits IN_WIDTH-bit words into IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit slices over
// valid/ready, counting fully emitted words. Build option: LEGALIZE_SPLIT_MSB_FIRST_EN.
module legalize_word_splitter
    import legalize_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int unsigned N         = num_slices(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned IDX_WIDTH = idx_width(N);
    localparam logic [IDX_WIDTH-1:0] IDX_ZERO = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(32'd1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    generate
        if (!widths_legal(IN_WIDTH, OUT_WIDTH)) begin : g_width_check
            $error("legalize_word_splitter: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
        end
    endgenerate

    split_state_e         state_r;
    logic [IDX_WIDTH-1:0] idx_r;
    logic [IN_WIDTH-1:0]  word_r;
    logic                 last_r;
    logic [CNT_WIDTH-1:0] count_r;

    logic                 at_last_s;
    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 out_fire_s;
    logic [OUT_WIDTH-1:0] slice_s;

    assign at_last_s = (idx_r == LAST_IDX);

    // Accept a new word when idle, or when the final slice leaves this very cycle.
    always_comb begin
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                SEND:    in_ready_s = at_last_s & out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    assign in_fire_s  = in_valid & in_ready_s;
    assign out_fire_s = (state_r == SEND) & out_ready;

    // Slice sequencing FSM, word/last holding registers and saturating word counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            word_r  <= {IN_WIDTH{1'b0}};
            last_r  <= 1'b0;
            count_r <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_fire_s) begin
                        state_r <= SEND;
                        idx_r   <= IDX_ZERO;
                        word_r  <= in_data;
                        last_r  <= in_last;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (!out_fire_s) begin
                        state_r <= SEND;
                    end else if (!at_last_s) begin
                        idx_r <= idx_r + IDX_ONE;
                    end else if (in_fire_s) begin
                        // Back-to-back word: reload without leaving SEND.
                        idx_r  <= IDX_ZERO;
                        word_r <= in_data;
                        last_r <= in_last;
                    end else begin
                        state_r <= IDLE;
                        idx_r   <= IDX_ZERO;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= IDX_ZERO;
                end
            endcase

            if (out_fire_s && at_last_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    legalize_slice_sel #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_slice_sel (
        .word  (word_r),
        .idx   (idx_r),
        .slice (slice_s)
    );

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == SEND);
    assign out_data   = slice_s;
    assign out_last   = last_r & at_last_s;
    assign word_count = count_r;

endmodule

// File: tb/tb_legalize_word_splitter.sv
// Self-checking bench for legalize_word_splitter: directed vector table, corner sequences
// and a randomized run against a slice-queue reference model.
module tb_legalize_word_splitter;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int N     = IN_W / OUT_W;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_ready;
    logic             in_ready, out_valid, out_last;
    logic [OUT_W-1:0] out_data;
    logic [15:0]      word_count;
    logic             in_ready_2, out_valid_2, out_last_2;
    logic [OUT_W-1:0] out_data_2;
    logic [1:0]       word_count_2;

    int checks   = 0;
    int failures = 0;

    legalize_word_splitter #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .word_count(word_count)
    );

    legalize_word_splitter #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(2)) u_dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_2), .out_ready(out_ready),
        .out_data(out_data_2), .out_last(out_last_2), .word_count(word_count_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic            iv;
        logic [IN_W-1:0] id;
        logic            il;
        logic            ordy;
        logic            e_ir;
        logic            e_ov;
        logic [OUT_W-1:0] e_od;
        logic            e_ol;
        int              e_cnt;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
        logic             wend;
    } slice_t;

    // k-th slice in emission order for this build
    function automatic logic [OUT_W-1:0] sl(input logic [IN_W-1:0] w, input int k);
        int pos;
`ifdef LEGALIZE_SPLIT_MSB_FIRST_EN
        pos = N - 1 - k;
`else
        pos = k;
`endif
        return w[pos*OUT_W +: OUT_W];
    endfunction

    function automatic vec_t mk(input logic iv, input logic [IN_W-1:0] id, input logic il,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [OUT_W-1:0] e_od, input logic e_ol, input int e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [IN_W-1:0] id, input logic il,
                        input logic ordy, input logic rst);
        @(negedge clock);
        in_valid  = iv;
        in_data   = id;
        in_last   = il;
        out_ready = ordy;
        reset     = rst;
        #1;
    endtask

    function automatic int sat3(input int c);
        return (c > 3) ? 3 : c;
    endfunction

    vec_t   vt[$];
    slice_t q[$];
    slice_t h;
    int     cnt;
    logic   m_ready;
    logic             r_iv, r_il, r_ordy;
    logic [IN_W-1:0]  r_id;
    logic [IN_W-1:0]  w;
    int     exp_sat[5];

    initial begin
        in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b0; reset = 1'b1;

        // Tests 1 and 2 as a cycle-by-cycle table
        vt.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 0));
        vt.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, sl(32'hDEADBEEF, 0), 1'b0, 0));
        vt.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, sl(32'hDEADBEEF, 1), 1'b1, 0));
        vt.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1));
        vt.push_back(mk(1'b1, 32'h00010002, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1));
        vt.push_back(mk(1'b1, 32'h00030004, 1'b0, 1'b1, 1'b0, 1'b1, sl(32'h00010002, 0), 1'b0, 1));
        vt.push_back(mk(1'b1, 32'h00030004, 1'b0, 1'b1, 1'b1, 1'b1, sl(32'h00010002, 1), 1'b0, 1));
        vt.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, sl(32'h00030004, 0), 1'b0, 2));
        vt.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, sl(32'h00030004, 1), 1'b0, 2));
        vt.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 3));

        // Reset state
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("reset_in_ready", in_ready, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 16'h0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_word_count", word_count, 16'h0);

        foreach (vt[i]) begin
            step(vt[i].iv, vt[i].id, vt[i].il, vt[i].ordy, 1'b0);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_ov);
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data, vt[i].e_od);
                chk($sformatf("vec%0d_out_last", i), out_last, vt[i].e_ol);
            end
            chk($sformatf("vec%0d_word_count", i), word_count, vt[i].e_cnt);
            chk($sformatf("vec%0d_sat_count", i), word_count_2, sat3(vt[i].e_cnt));
        end

        // Test 3: backpressure holds slice 0
        w = 32'hCAFEF00D;
        step(1'b1, w, 1'b0, 1'b0, 1'b0);
        chk("bp_accept_ready", in_ready, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, sl(w, 0));
            chk("bp_hold_in_ready", in_ready, 1'b0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_slice0", out_data, sl(w, 0));
        chk("bp_slice0_in_ready", in_ready, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_slice1", out_data, sl(w, 1));
        chk("bp_slice1_last", out_last, 1'b0);
        chk("bp_slice1_in_ready", in_ready, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("bp_done_valid", out_valid, 1'b0);
        chk("bp_done_count", word_count, 16'd4);

        // Test 4: reset mid-word discards the rest
        w = 32'h12345678;
        step(1'b1, w, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("mid_slice0", out_data, sl(w, 0));
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_reset_in_ready", in_ready, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            chk("mid_after_valid", out_valid, 1'b0);
            chk("mid_after_count", word_count, 16'd0);
            chk("mid_after_data", out_data, 16'h0);
            chk("mid_after_last", out_last, 1'b0);
        end

        // Test 5: 2-bit counter saturates
        exp_sat = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 32'h1000 + k, k[0], 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            chk("sat_word_last", out_last, k[0]);
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            chk("sat_count", word_count_2, exp_sat[k]);
            chk("sat_wide_count", word_count, k + 1);
        end

        // Randomized run against the slice-queue model
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        for (int c = 0; c < 600; c++) begin
            r_iv   = ($urandom_range(0, 3) != 0);
            r_id   = $urandom;
            r_il   = $urandom_range(0, 1);
            r_ordy = ($urandom_range(0, 3) != 0);
            step(r_iv, r_id, r_il, r_ordy, 1'b0);
            m_ready = (q.size() == 0) || (q.size() == 1 && r_ordy);
            chk("rnd_in_ready", in_ready, m_ready);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_out_data", out_data, q[0].d);
                chk("rnd_out_last", out_last, q[0].l);
            end
            chk("rnd_word_count", word_count, cnt);
            chk("rnd_sat_count", word_count_2, sat3(cnt));
            if (q.size() != 0 && r_ordy) begin
                h = q.pop_front();
                if (h.wend) cnt++;
            end
            if (r_iv && m_ready) begin
                for (int k = 0; k < N; k++) begin
                    q.push_back('{sl(r_id, k), r_il && (k == N - 1), k == N - 1});
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
